// File: rtl/pc_next_unit.sv
// Registered next-PC unit: selects PC+4 or the branch target PC+4+(sext(imm16)<<2) and registers it.
// Optional build macro PC_WRAP_FLAG_EN adds a registered pc_wrap overflow flag.

module pc_adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};
endmodule

// Only the low 30 bits reach the shifter; the two dropped bits would fall off the top anyway.
module pc_shl2 (
  input  logic [29:0] din,
  output logic [31:0] dout
);
  assign dout = {din, 2'b00};
endmodule

module pc_mux2 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sel,
  output logic [31:0] y
);
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_bit
      assign y[gi] = sel ? b[gi] : a[gi];
    end
  endgenerate
endmodule

module pc_next_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] p_in,
  input  logic [15:0] instruct,
  input  logic        control,
  output logic [31:0] pc_plus4,
  output logic [31:0] p_out
`ifdef PC_WRAP_FLAG_EN
  , output logic      pc_wrap
`endif
);
  logic [29:0] ext_low;
  logic [31:0] off;
  logic [31:0] tgt;
  logic [31:0] sel_next;
  logic [31:0] p_out_reg;
`ifdef PC_WRAP_FLAG_EN
  logic        carry_a;
  logic [34:0] exact_tgt;
  logic        wrap_next;
  logic        wrap_reg;
`else
  logic        carry_a_unused;
`endif
  logic        carry_b_unused;

  assign ext_low = {{14{instruct[15]}}, instruct};

  pc_adder32 u_adder_a (
    .a    (p_in),
    .b    (32'd4),
    .cin  (1'b0),
    .sum  (pc_plus4),
`ifdef PC_WRAP_FLAG_EN
    .cout (carry_a)
`else
    .cout (carry_a_unused)
`endif
  );

  pc_shl2 u_shl2 (
    .din  (ext_low),
    .dout (off)
  );

  pc_adder32 u_adder_b (
    .a    (pc_plus4),
    .b    (off),
    .cin  (1'b0),
    .sum  (tgt),
    .cout (carry_b_unused)
  );

  pc_mux2 u_mux (
    .a   (pc_plus4),
    .b   (tgt),
    .sel (control),
    .y   (sel_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_out_reg <= RESET_PC;
    end else begin
      p_out_reg <= sel_next;
    end
  end

  assign p_out = p_out_reg;

`ifdef PC_WRAP_FLAG_EN
  // Exact branch sum in 35 bits: any set bit above bit 31 means below 0 or above 2^32-1.
  assign exact_tgt = {3'b000, p_in} + 35'd4 + {{3{instruct[15]}}, ext_low, 2'b00};
  assign wrap_next = control ? (exact_tgt[34:32] != 3'b000) : carry_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_reg <= 1'b0;
    end else begin
      wrap_reg <= wrap_next;
    end
  end

  assign pc_wrap = wrap_reg;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: table-driven datapath vectors plus reset and clock-discipline sequences.
// Checks pc_wrap as well when built with PC_WRAP_FLAG_EN.

module tb_pc_next_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] p_in;
  logic [15:0] instruct;
  logic        control;
  logic [31:0] pc_plus4;
  logic [31:0] p_out;
`ifdef PC_WRAP_FLAG_EN
  logic        pc_wrap;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  pc_next_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .p_in     (p_in),
    .instruct (instruct),
    .control  (control),
    .pc_plus4 (pc_plus4),
    .p_out    (p_out)
`ifdef PC_WRAP_FLAG_EN
    , .pc_wrap (pc_wrap)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] p_in;
    logic [15:0] imm;
    logic        ctl;
    logic [31:0] exp_plus4;
    logic [31:0] exp_out;
    logic        exp_wrap;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic chk_wrap(input string name, input logic exp);
`ifdef PC_WRAP_FLAG_EN
    chk(name, {31'd0, pc_wrap}, {31'd0, exp});
`else
    if (exp === 1'bx) $display("note: %s unused", name);
`endif
  endtask

  initial begin
    vecs[0]  = '{32'h0000_0100, 16'h0000, 1'b0, 32'h0000_0104, 32'h0000_0104, 1'b0};
    vecs[1]  = '{32'h0000_0100, 16'h0003, 1'b1, 32'h0000_0104, 32'h0000_0110, 1'b0};
    vecs[2]  = '{32'h0000_0100, 16'hFFFF, 1'b1, 32'h0000_0104, 32'h0000_0100, 1'b0};
    vecs[3]  = '{32'h0000_0100, 16'h8000, 1'b1, 32'h0000_0104, 32'hFFFE_0104, 1'b1};
    vecs[4]  = '{32'hFFFF_FFFC, 16'h1234, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[5]  = '{32'h7FFF_FFF0, 16'h0002, 1'b1, 32'h7FFF_FFF4, 32'h7FFF_FFFC, 1'b0};
    vecs[6]  = '{32'h0000_0000, 16'hFFFF, 1'b1, 32'h0000_0004, 32'h0000_0000, 1'b0};
    vecs[7]  = '{32'hFFFF_FFF0, 16'h0010, 1'b1, 32'hFFFF_FFF4, 32'h0000_0034, 1'b1};
    vecs[8]  = '{32'hFFFF_FFFC, 16'hFFFF, 1'b1, 32'h0000_0000, 32'hFFFF_FFFC, 1'b0};
    vecs[9]  = '{32'h0000_0100, 16'h0003, 1'b0, 32'h0000_0104, 32'h0000_0104, 1'b0};
    vecs[10] = '{32'h1234_5678, 16'h7FFF, 1'b1, 32'h1234_567C, 32'h1236_5678, 1'b0};

    // Power-on reset: output forced without any clock edge, pc_plus4 still live.
    rst_n = 1'b0; p_in = 32'h0000_0040; instruct = 16'h0000; control = 1'b0;
    #2;
    chk("reset_p_out", p_out, 32'h0);
    chk("reset_plus4", pc_plus4, 32'h0000_0044);
    chk_wrap("reset_wrap", 1'b0);
    @(posedge clk); #1;
    chk("reset_hold_edge", p_out, 32'h0);
    $display("txn reset: p_out=%08h pc_plus4=%08h", p_out, pc_plus4);
    rst_n = 1'b1;
    #1;
    chk("release_no_edge", p_out, 32'h0);
    @(posedge clk); #1;
    chk("first_capture", p_out, 32'h0000_0044);

    // Async reset from a non-zero output, then release between edges.
    p_in = 32'h0000_01FC;
    @(posedge clk); #1;
    chk("pre_reset_load", p_out, 32'h0000_0200);
    #2; rst_n = 1'b0; #1;
    chk("async_reset", p_out, 32'h0);
    #1; rst_n = 1'b1; #1;
    chk("post_release_hold", p_out, 32'h0);
    @(posedge clk); #1;
    chk("post_release_load", p_out, 32'h0000_0200);
    $display("txn async_reset: p_out=%08h", p_out);

    for (int i = 0; i < 11; i++) begin
      p_in = vecs[i].p_in; instruct = vecs[i].imm; control = vecs[i].ctl;
      #1;
      chk($sformatf("vec%0d_plus4", i), pc_plus4, vecs[i].exp_plus4);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_p_out", i), p_out, vecs[i].exp_out);
      chk_wrap($sformatf("vec%0d_wrap", i), vecs[i].exp_wrap);
      $display("txn vec%0d: p_in=%08h imm=%04h ctl=%0b pc_plus4=%08h p_out=%08h",
               i, p_in, instruct, control, pc_plus4, p_out);
    end

    // Clock discipline: mid-cycle input changes and the falling edge leave p_out alone.
    p_in = 32'h0000_0500; control = 1'b0; instruct = 16'h0001;
    @(posedge clk); #1;
    chk("disc_base", p_out, 32'h0000_0504);
    p_in = 32'h0000_0600; control = 1'b1;
    @(negedge clk); #1;
    chk("disc_negedge", p_out, 32'h0000_0504);
    p_in = 32'h0000_0700; control = 1'b0;
    #2;
    chk("disc_midcycle", p_out, 32'h0000_0504);
    @(posedge clk); #1;
    chk("disc_capture", p_out, 32'h0000_0704);
    $display("txn discipline: p_out=%08h", p_out);

    // Reset mid-stream: pending capture is lost, next edge after release loads current sel.
    p_in = 32'h0000_1000; control = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("stream%0d", i), p_out, 32'h0000_1000 + 32'(4 * i));
      p_in = 32'h0000_1000 + 32'(4 * i);
    end
    #2; rst_n = 1'b0; #1;
    chk("stream_reset", p_out, 32'h0);
    #1; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("stream_resume", p_out, 32'h0000_1010);
    $display("txn stream_reset: p_out=%08h", p_out);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
